// File: rtl/cal_pkg.sv
// Shared calendar definitions: month numbers, month-length constants and
// the Gregorian leap-year test used by calendar_counter and days_in_month.
package cal_pkg;

  localparam logic [3:0] JAN = 4'd1;
  localparam logic [3:0] FEB = 4'd2;
  localparam logic [3:0] MAR = 4'd3;
  localparam logic [3:0] APR = 4'd4;
  localparam logic [3:0] MAY = 4'd5;
  localparam logic [3:0] JUN = 4'd6;
  localparam logic [3:0] JUL = 4'd7;
  localparam logic [3:0] AUG = 4'd8;
  localparam logic [3:0] SEP = 4'd9;
  localparam logic [3:0] OCT = 4'd10;
  localparam logic [3:0] NOV = 4'd11;
  localparam logic [3:0] DEC = 4'd12;

  localparam logic [4:0] D28 = 5'd28;
  localparam logic [4:0] D29 = 5'd29;
  localparam logic [4:0] D30 = 5'd30;
  localparam logic [4:0] D31 = 5'd31;

  // Year is passed zero-extended to 32 bits so one function serves any YEAR_W.
  // With leap_en low February is always treated as a 28-day month.
  function automatic logic is_leap(input logic [31:0] y, input logic leap_en);
    return leap_en && ((y % 32'd4) == 32'd0) &&
           (((y % 32'd100) != 32'd0) || ((y % 32'd400) == 32'd0));
  endfunction

endpackage

// File: rtl/calendar_counter_days_in_month.sv
// Combinational month-length lookup.
// Ports:
//   month  in  4  month number, 1-based
//   leap   in  1  year is a leap year
//   ndays  out 5  days in that month; 0 for a month outside 1..12
module days_in_month
  import cal_pkg::*;
(
  input  logic [3:0] month,
  input  logic       leap,
  output logic [4:0] ndays
);

  always_comb begin
    ndays = 5'd0;
    case (month)
      FEB:                               ndays = leap ? D29 : D28;
      APR, JUN, SEP, NOV:                ndays = D30;
      JAN, MAR, MAY, JUL, AUG, OCT, DEC: ndays = D31;
      default:                           ndays = 5'd0;
    endcase
  end

endmodule

// File: rtl/calendar_counter.sv
// Day/month/year calendar register advanced by a once-per-day tick, with
// validated parallel load and month/year roll-over pulses.
// Ports:
//   clk        in   1       system clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   tick       in   1       advance one day
//   load       in   1       load ld_day/ld_month/ld_year (wins over tick)
//   ld_day     in   5       day to load
//   ld_month   in   4       month to load
//   ld_year    in   YEAR_W  year to load
//   day        out  5       current day, 1-based
//   month      out  4       current month, 1-based
//   year       out  YEAR_W  current year
//   err        out  1       last load was rejected
//   month_end  out  1       one-cycle pulse on month roll-over
//   year_end   out  1       one-cycle pulse on year roll-over
module calendar_counter
  import cal_pkg::*;
#(
  parameter int YEAR_W     = 12,
  parameter int RESET_YEAR = 2000,
  parameter int LEAP_EN    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              load,
  input  logic [4:0]        ld_day,
  input  logic [3:0]        ld_month,
  input  logic [YEAR_W-1:0] ld_year,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic              err,
  output logic              month_end,
  output logic              year_end
);

  logic       cur_leap;
  logic       ld_leap;
  logic [4:0] cur_ndays;
  logic [4:0] ld_ndays;
  logic       ld_valid;

  assign cur_leap = is_leap(32'(year), LEAP_EN != 0);
  assign ld_leap  = is_leap(32'(ld_year), LEAP_EN != 0);

  days_in_month u_dim_cur (
    .month (month),
    .leap  (cur_leap),
    .ndays (cur_ndays)
  );

  days_in_month u_dim_ld (
    .month (ld_month),
    .leap  (ld_leap),
    .ndays (ld_ndays)
  );

  // An out-of-range month yields ndays=0, so the day bound alone rejects it;
  // the explicit month range check keeps the intent readable.
  assign ld_valid = (ld_month >= JAN) && (ld_month <= DEC) &&
                    (ld_day != 5'd0) && (ld_day <= ld_ndays);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day       <= 5'd1;
      month     <= JAN;
      year      <= YEAR_W'(RESET_YEAR);
      err       <= 1'b0;
      month_end <= 1'b0;
      year_end  <= 1'b0;
    end else if (load) begin
      // A tick arriving with load is dropped, not deferred.
      month_end <= 1'b0;
      year_end  <= 1'b0;
      if (ld_valid) begin
        day   <= ld_day;
        month <= ld_month;
        year  <= ld_year;
        err   <= 1'b0;
      end else begin
        err   <= 1'b1;
      end
    end else if (tick) begin
      // Loads are validated, so day never exceeds cur_ndays here.
      if (day < cur_ndays) begin
        day       <= day + 5'd1;
        month_end <= 1'b0;
        year_end  <= 1'b0;
      end else if (month < DEC) begin
        day       <= 5'd1;
        month     <= month + 4'd1;
        month_end <= 1'b1;
        year_end  <= 1'b0;
      end else begin
        day       <= 5'd1;
        month     <= JAN;
        year      <= year + YEAR_W'(1);   // wraps modulo 2^YEAR_W
        month_end <= 1'b1;
        year_end  <= 1'b1;
      end
    end else begin
      month_end <= 1'b0;
      year_end  <= 1'b0;
    end
  end

endmodule

// File: doc/calendar_counter.md
Name: calendar_counter

Overview:
- Sequential day/month/year calendar register; the parametrised successor of the combinational today/tomorrow day incrementer.
- Advances one day per `tick` strobe.
- Supports validated parallel load, Gregorian leap years and month/year roll-over pulses.
- Sits beside the RTC prescaler, which supplies `tick` (one pulse per day).

Parameters:
- YEAR_W, 12, width of the year field (absolute year 0..2^YEAR_W-1).
- RESET_YEAR, 2000, year value loaded on reset.
- LEAP_EN, 1, 1 = full Gregorian leap rule; 0 = February always 28 days.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tick  input  1  advance date by one day (single-cycle strobe).
- load  input  1  load ld_day/ld_month/ld_year.
- ld_day  input  5  day to load (1..31).
- ld_month  input  4  month to load (1..12).
- ld_year  input  YEAR_W  year to load.
- day  output  5  current day, 1-based.
- month  output  4  current month, 1-based.
- year  output  YEAR_W  current year.
- err  output  1  last load was invalid (registered).
- month_end  output  1  one-cycle pulse: a month roll-over occurred.
- year_end  output  1  one-cycle pulse: a year roll-over occurred.

Behaviour:
- Reset (async assert, sync release):
  - day=1, month=1, year=RESET_YEAR.
  - err=0, month_end=0, year_end=0.
- All outputs are registered; every update is visible the cycle after the qualifying edge.
- Leap rule (LEAP_EN=1): leap = (y%4==0) && ((y%100!=0) || (y%400==0)).
- Month lengths:
  - February = 29 if leap, else 28.
  - April, June, September, November = 30; all other months = 31.
- ndays(m,y): 5-bit result; for m outside 1..12 it returns 0.
- Priority: load > tick > hold.
- Load:
  - Valid iff 1<=ld_month<=12 and 1<=ld_day<=ndays(ld_month,ld_year).
  - Valid: day/month/year take the load values; err<=0.
  - Invalid: date unchanged; err<=1.
  - err holds until the next load and is not affected by tick.
  - Pulses are 0 in any load cycle.
- Tick (load=0):
  - day<ndays(month,year): day<=day+1.
  - day==ndays, month<12: day<=1; month<=month+1; month_end<=1.
  - day==ndays, month==12: day<=1; month<=1; year<=year+1; month_end<=1; year_end<=1.
  - Year wraps from 2^YEAR_W-1 to 0 (modulo arithmetic, no flag).
- Simultaneous load and tick: the tick is discarded, with no catch-up on later cycles.
- Idle cycles: month_end and year_end are 0 whenever the previous cycle did not roll over. Each pulse lasts exactly one cycle, even with back-to-back ticks.
- Reset asserted mid-operation: every output returns to its reset value immediately, independent of clk.
- State is always valid after reset and after any load, so day>ndays cannot arise in the register.

Decomposition:
- Shared package cal_pkg:
  - Month constants JAN..DEC (4-bit).
  - Day-length constants D28, D29, D30, D31.
  - Function is_leap(year, LEAP_EN).
- One sub-module, days_in_month:
  - Combinational; inputs month[3:0] and leap; output ndays[4:0].
  - Two instances: one for the current date (tick path), one for the ld_* inputs (validation path).

Test Plan:
- Reset, then rst_n released with no tick -> day=1, month=1, year=2000, err=0, no pulses.
- Load 28/2/2023, tick -> 1/3/2023, month_end=1 for exactly one cycle. Load 28/2/2024, tick -> 29/2/2024. Load 28/2/1900, tick -> 1/3/1900. Load 28/2/2000, tick -> 29/2/2000.
- Load 31/12/2099, tick -> 1/1/2100 with month_end=1 and year_end=1 in the same cycle. Load 31/12/4095, tick -> 1/1/0 (wrap).
- Load 31/4/2024 -> err=1, date unchanged. Load 30/4/2024 -> err=0, date 30/4. Load 5/13/2024 or 0/1/2024 -> err=1.
- load and tick in the same cycle with 10/6/2024 -> date = 10/6/2024 (tick dropped), no pulses.
- 366 consecutive ticks from 1/1/2024 -> 1/1/2025, with exactly 12 month_end pulses and 1 year_end pulse. Assert rst_n mid-sequence -> outputs reset immediately.
